// File: rtl/window_sum_ignore_if.sv
// Sample/sum bundle for window_sum_ignore: source drives en/clr/d,
// the accumulator returns the registered window sum and status.
interface window_sum_ignore_if #(
  parameter int w = 4,
  parameter int n = 4
);
  localparam int QW = w + $clog2(n);
  localparam int CW = $clog2(n) + 1;

  logic          en;
  logic          clr;
  logic [w-1:0]  d;
  logic [QW-1:0] q;
  logic [CW-1:0] cnt;
  logic          full;
  logic          upd;

  modport master (output en, output clr, output d,
                  input q, input cnt, input full, input upd);
  modport slave  (input en, input clr, input d,
                  output q, output cnt, output full, output upd);
endinterface

// File: rtl/window_sum_ignore.sv
// Sliding-window accumulator: registered sum of the last n accepted samples,
// where samples equal to ign (or with en low) are skipped.
module window_sum_ignore #(
  parameter int           w   = 4,
  parameter int           n   = 4,
  parameter logic [w-1:0] ign = {w{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_b,
  window_sum_ignore_if.slave bus
);
  localparam int QW = w + $clog2(n);
  localparam int CW = $clog2(n) + 1;
  localparam logic [CW-1:0] N_CNT = CW'(n);

  typedef enum logic [0:0] {
    ST_FILLING = 1'b0,
    ST_FULL    = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [n-1:0][w-1:0] win_r, win_s;
  logic [QW-1:0]       q_r, q_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic                full_r;
  logic                upd_r, upd_s;
  logic                acc_s;

  assign acc_s = bus.en && (bus.d != ign) && !bus.clr;

  // Next-state: clear wins over a sample; index 0 is newest, n-1 is oldest.
  always_comb begin
    state_s = state_r;
    win_s   = win_r;
    q_s     = q_r;
    cnt_s   = cnt_r;
    upd_s   = 1'b0;
    if (bus.clr) begin
      win_s   = '0;
      q_s     = {QW{1'b0}};
      cnt_s   = {CW{1'b0}};
      state_s = ST_FILLING;
    end else if (acc_s) begin
      win_s[0] = bus.d;
      for (int i = 1; i < n; i++) begin
        win_s[i] = win_r[i-1];
      end
      // Unfilled slots hold 0, so evicting them is harmless while filling.
      q_s   = q_r + QW'(bus.d) - QW'(win_r[n-1]);
      upd_s = 1'b1;
      case (state_r)
        ST_FILLING: begin
          cnt_s = cnt_r + CW'(1);
          if (cnt_r == N_CNT - CW'(1)) begin
            state_s = ST_FULL;
          end else begin
            state_s = ST_FILLING;
          end
        end
        ST_FULL: begin
          cnt_s   = N_CNT;
          state_s = ST_FULL;
        end
        default: begin
          cnt_s   = {CW{1'b0}};
          state_s = ST_FILLING;
        end
      endcase
    end else begin
      upd_s = 1'b0;
    end
  end

  // State and output registers with immediate asynchronous clear.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= ST_FILLING;
      win_r   <= '0;
      q_r     <= {QW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      full_r  <= 1'b0;
      upd_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      win_r   <= win_s;
      q_r     <= q_s;
      cnt_r   <= cnt_s;
      full_r  <= (state_s == ST_FULL);
      upd_r   <= upd_s;
    end
  end

  assign bus.q    = q_r;
  assign bus.cnt  = cnt_r;
  assign bus.full = full_r;
  assign bus.upd  = upd_r;
endmodule
